fetch_align_queue: RTL and testbench
====================================

// Module: fetch_align_queue
// PURPOSE
//  Parametrised instruction fetch/alignment queue between instruction SRAM and decode.
//  Issues aligned FETCH_W-bit word requests and buffers returned data as halfwords.
//  Extracts mixed RV32/RV16 instructions, including ones crossing word boundaries.
//  Drops in-flight responses on redirect and supports multiple outstanding requests.
// PARAMETERS
//  FETCH_W    64            SRAM word width in bits; power of 2, >=32
//  DEPTH_HW   8             queue capacity in halfwords; power of 2, >= 2*FETCH_W/16
//  OUTST      2             max outstanding SRAM requests, 1..4
//  BOOT_ADDR  32'h0000_0000 PC after reset; bit0 must be 0
// PORTS
//  clk          in   1              clock, all state on rising edge
//  cpurst_n     in   1              asynchronous active-low reset
//  flush        in   1              redirect (branch mispredict/trap); restart at flush_pc
//  flush_pc     in   32             redirect target; bit0 ignored
//  req_valid    out  1              SRAM read request
//  req_adr      out  32-log2(FETCH_W/8)  word address of request
//  req_ready    in   1              SRAM accepts request this cycle
//  rsp_valid    in   1              read data valid; in order, >=1 cycle after accept
//  rsp_data     in   FETCH_W        read data, little-endian halfwords
//  instr_valid  out  1              instr/instr_pc/instr_rv16 valid to decode
//  instr        out  32             instruction; RV16 zero-extended in [31:16]
//  instr_pc     out  32             PC of instr
//  instr_rv16   out  1              instr is compressed (head halfword [1:0]!=2'b11)
//  instr_ready  in   1              decode accepts (= !de_stall)
// BEHAVIOUR
//  Reset (async, cpurst_n=0): queue empty, count=0, outst=0, drop=0; req_valid=0,
//   instr_valid=0, instr=0, instr_rv16=0, instr_pc=BOOT_ADDR, req_adr=BOOT_ADDR word.
//   Reset mid-operation discards all queued and in-flight data; responses then ignored.
//  Reservation: req_valid=1 when !flush and
//   count + (outst+accepted-not-yet-returned)*FETCH_W/16 + FETCH_W/16 <= DEPTH_HW and outst<OUTST.
//   Accept = req_valid & req_ready: outst++, req_adr += 1. req_valid/req_adr held while !req_ready.
//  Response: rsp_valid with drop>0 -> drop--, data discarded, outst--. Else halfwords pushed
//   at tail, outst--; first word after redirect/reset skips halfwords below PC offset
//   (PC[log2(FETCH_W/8)-1:1]), pushing only the remainder.
//  Extract (combinational from head): head hw [1:0]!=2'b11 -> rv16, needs 1 hw;
//   else needs 2 hw. instr_valid = count >= need. A 32-bit instr with only 1 hw queued
//   (word-boundary split) waits with instr_valid=0 until next word arrives.
//  Pop on instr_valid & instr_ready: head += need, instr_pc += 2 or 4; push and pop in
//   same cycle both apply (count += pushed - popped). Pointers wrap mod DEPTH_HW.
//  Flush (priority over push, pop, accept): queue emptied, drop <= outst (+1 if a
//   response arrives that cycle is excluded, i.e. drop <= outst - rsp_valid), instr_pc <= flush_pc
//   & ~1, req_adr <= flush_pc word; req_valid=0 in flush cycle, may assert next cycle.
//   instr_valid=0 in the cycle after flush until new data arrives.
//  Back-to-back flushes: each reloads PC; drop accumulates correctly, never underflows.
//  Invariants: count<=DEPTH_HW; never overflows since space is reserved at accept.
// TESTING
//  Reset, req_ready=1, 1-cycle SRAM, words of 32-bit instrs -> instr_pc 0,4,8.. one per cycle.
//  Word 0x0001_0013_4501_4581 (rv16,rv16,rv32) -> instrs 4581/4501 (rv16), 0x00010013 at pc 4.
//  rv32 at pc 6 split across words -> instr_valid=0 until word 1, then instr at pc 6.
//  flush_pc=0x106 with 2 outstanding -> both responses dropped, first instr_pc=0x106.
//  instr_ready=0 for 20 cycles -> req_valid drops when full, no data lost, order preserved.
//  cpurst_n low mid-burst -> outputs reset immediately; restart at BOOT_ADDR.

Source files
------------

// File: rtl/fetch_align_queue.sv
// fetch_align_queue
//   Fetch/alignment queue between the instruction SRAM and decode. It issues
//   aligned FETCH_W-bit word reads and stores the returned data as halfwords
//   in a circular queue. Mixed 16/32-bit instructions are extracted from the
//   head, including 32-bit ones that straddle a word boundary. A redirect
//   drops every response still in flight and restarts fetch at flush_pc.
// Ports
//   clk, cpurst_n              clock, asynchronous active-low reset
//   flush, flush_pc            redirect request and target PC (bit0 ignored)
//   req_valid/req_adr/req_ready   SRAM word read request handshake
//   rsp_valid/rsp_data         in-order SRAM read data
//   instr_valid/instr/instr_pc/instr_rv16/instr_ready   decode handshake
module fetch_align_queue #(
  parameter int unsigned FETCH_W   = 64,
  parameter int unsigned DEPTH_HW  = 8,
  parameter int unsigned OUTST     = 2,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          cpurst_n,
  input  logic                          flush,
  input  logic [31:0]                   flush_pc,
  output logic                          req_valid,
  output logic [31-$clog2(FETCH_W/8):0] req_adr,
  input  logic                          req_ready,
  input  logic                          rsp_valid,
  input  logic [FETCH_W-1:0]            rsp_data,
  output logic                          instr_valid,
  output logic [31:0]                   instr,
  output logic [31:0]                   instr_pc,
  output logic                          instr_rv16,
  input  logic                          instr_ready
);
  localparam int unsigned HPW  = FETCH_W / 16;
  localparam int unsigned WOFF = $clog2(FETCH_W / 8);
  localparam int unsigned OFFW = WOFF - 1;
  localparam int unsigned AW   = 32 - WOFF;
  localparam int unsigned PW   = $clog2(DEPTH_HW);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned OW   = 3;

  logic [15:0]   mem_q [DEPTH_HW];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] outst_q, outst_d, drop_q, drop_d;
  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] adr_q, adr_d;
  logic          skip_q, skip_d;
  logic          run_q;

  logic [15:0]   hd0, hd1;
  logic          is_rv16, pop, rsp_ok, rsp_take, accept, space_ok;
  logic [CW-1:0] need, npush;
  logic [OFFW-1:0] skip_off;
  logic [31:0]   resv;

  always_comb begin
    hd0         = mem_q[head_q];
    hd1         = mem_q[head_q + PW'(1)];
    is_rv16     = (hd0[1:0] != 2'b11);
    need        = is_rv16 ? CW'(1) : CW'(2);
    instr_valid = (count_q >= need);
    instr       = '0;
    if (instr_valid) instr = is_rv16 ? {16'h0000, hd0} : {hd1, hd0};
    instr_rv16  = instr_valid & is_rv16;
    instr_pc    = pc_q;
    pop         = instr_valid & instr_ready & ~flush;

    // A response with nothing outstanding is stale (e.g. issued before a
    // reset) and is ignored.
    rsp_ok   = rsp_valid & (outst_q != '0);
    rsp_take = rsp_ok & (drop_q == '0);
    // The first word after a redirect starts at the PC's halfword offset;
    // the queue is empty then, so pc_q still holds the redirect target.
    skip_off = skip_q ? pc_q[WOFF-1:1] : '0;
    npush    = rsp_take ? (CW'(HPW) - CW'(skip_off)) : '0;

    // Space for every outstanding word plus the new one is reserved at
    // request time, so a response can always be pushed.
    resv      = 32'(count_q) + 32'(outst_q) * 32'(HPW) + 32'(HPW);
    space_ok  = (resv <= 32'(DEPTH_HW));
    req_valid = run_q & ~flush & space_ok & (32'(outst_q) < 32'(OUTST));
    req_adr   = adr_q;
    accept    = req_valid & req_ready;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    outst_d = outst_q;
    drop_d  = drop_q;
    pc_d    = pc_q;
    adr_d   = adr_q;
    skip_d  = skip_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      // A response landing in the flush cycle retires its own request.
      outst_d = outst_q - OW'(rsp_ok);
      drop_d  = outst_q - OW'(rsp_ok);
      pc_d    = flush_pc & ~32'h1;
      adr_d   = flush_pc[31:WOFF];
      skip_d  = 1'b1;
    end else begin
      outst_d = outst_q + OW'(accept) - OW'(rsp_ok);
      if (rsp_ok && drop_q != '0) drop_d = drop_q - OW'(1);
      if (accept) adr_d = adr_q + AW'(1);
      if (rsp_take) begin
        tail_d = tail_q + PW'(npush);
        skip_d = 1'b0;
      end
      if (pop) begin
        head_d = head_q + PW'(need);
        pc_d   = pc_q + (is_rv16 ? 32'd2 : 32'd4);
      end
      count_d = count_q + npush - (pop ? need : CW'(0));
    end
  end

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      outst_q <= '0;
      drop_q  <= '0;
      pc_q    <= BOOT_ADDR & ~32'h1;
      adr_q   <= BOOT_ADDR[31:WOFF];
      skip_q  <= 1'b1;
      run_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      pc_q    <= pc_d;
      adr_q   <= adr_d;
      skip_q  <= skip_d;
      run_q   <= 1'b1;
    end
  end

  // Halfword storage holds no control state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (rsp_take && !flush) begin
      for (int i = 0; i < int'(HPW); i++) begin
        if (OFFW'(i) >= skip_off)
          mem_q[tail_q + PW'(i) - PW'(skip_off)] <= rsp_data[16*i +: 16];
      end
    end
  end

endmodule

// File: tb/tb_fetch_align_queue.sv
// tb_fetch_align_queue
//   Drives fetch_align_queue (FETCH_W=64, DEPTH_HW=8, OUTST=2) from an SRAM
//   model with a fixed program image and variable latency. The reference
//   model tracks only the architectural PC: whatever decode is handed must be
//   the instruction found in the image at that PC.
module tb_fetch_align_queue;
  localparam logic [31:0] BOOT = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        cpurst_n, flush, req_valid, req_ready, rsp_valid;
  logic        instr_valid, instr_rv16, instr_ready;
  logic [31:0] flush_pc, instr, instr_pc;
  logic [28:0] req_adr;
  logic [63:0] rsp_data;

  always #5 clk = ~clk;

  fetch_align_queue #(.FETCH_W(64), .DEPTH_HW(8), .OUTST(2), .BOOT_ADDR(BOOT)) dut (
    .clk(clk), .cpurst_n(cpurst_n), .flush(flush), .flush_pc(flush_pc),
    .req_valid(req_valid), .req_adr(req_adr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_rv16(instr_rv16), .instr_ready(instr_ready)
  );

  int checks = 0, failures = 0;
  logic [63:0] image [256];
  logic [28:0] sq_adr [$];
  int          sq_due [$];
  int          cyc = 0, last_due = 0, lat_lo = 1, lat_hi = 1, slow_word = -1;
  int          ir_mode = 0, retired = 0, wait14 = 0;
  bit          rr_rand = 0, prev_fl = 0, expect_stream = 0, watch14 = 0, last_req_valid;
  logic [31:0] mpc = BOOT;
  logic [28:0] exp_adr = BOOT[31:3];
  logic [31:0] log_pc [$], log_in [$];
  bit          log_rv [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [63:0] w;
    w = image[a[10:3]];
    return w[a[2:1]*16 +: 16];
  endfunction

  task automatic step(input bit fl, input logic [31:0] fpc);
    int lat, due, n_out;
    logic [15:0] h0, h1;
    logic [31:0] e;
    @(negedge clk);
    flush    = fl;
    flush_pc = fpc;
    req_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    case (ir_mode)
      0:       instr_ready = 1'b1;
      1:       instr_ready = 1'b0;
      default: instr_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (sq_adr.size() > 0 && sq_due[0] <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = image[sq_adr[0][7:0]];
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = {$urandom, $urandom};
    end
    #1;
    if (fl) chk("req_valid_in_flush", req_valid, 0);
    if (prev_fl) chk("instr_valid_after_flush", instr_valid, 0);
    if (expect_stream) chk("stream_valid", instr_valid, 1);
    chk("instr_pc", instr_pc, mpc);
    if (req_valid) chk("req_adr", req_adr, exp_adr);
    h0 = hw_at(mpc);
    h1 = hw_at(mpc + 32'd2);
    if (instr_valid) begin
      e = (h0[1:0] != 2'b11) ? {16'h0, h0} : {h1, h0};
      chk("instr", instr, e);
      chk("instr_rv16", instr_rv16, (h0[1:0] != 2'b11));
    end
    if (watch14 && instr_pc == 32'd14 && !instr_valid) wait14++;
    last_req_valid = req_valid;
    n_out = sq_adr.size();
    if (rsp_valid) begin
      void'(sq_adr.pop_front());
      void'(sq_due.pop_front());
    end
    if (req_valid && req_ready) begin
      chk("outstanding_limit", (n_out < 2), 1);
      lat = (slow_word >= 0 && int'(req_adr) == slow_word) ? 12 : int'($urandom_range(lat_lo, lat_hi));
      due = cyc + lat;
      if (due < last_due) due = last_due;
      last_due = due;
      sq_adr.push_back(req_adr);
      sq_due.push_back(due);
      exp_adr++;
    end
    if (fl) begin
      mpc     = fpc & ~32'h1;
      exp_adr = fpc[31:3];
    end else if (instr_valid && instr_ready) begin
      log_pc.push_back(mpc);
      log_in.push_back(instr);
      log_rv.push_back(instr_rv16);
      mpc = mpc + ((h0[1:0] != 2'b11) ? 32'd2 : 32'd4);
      retired++;
    end
    prev_fl = fl;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    cpurst_n = 1'b0; flush = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; instr_ready = 1'b0;
    #1;
    chk("rst_req_valid", req_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_rv16", instr_rv16, 0);
    chk("rst_instr_pc", instr_pc, BOOT);
    chk("rst_req_adr", req_adr, BOOT[31:3]);
    sq_adr.delete(); sq_due.delete();
    last_due = 0; mpc = BOOT; exp_adr = BOOT[31:3]; prev_fl = 0;
    log_pc.delete(); log_in.delete(); log_rv.delete();
    repeat (2) @(negedge clk);
    cpurst_n = 1'b1;
  endtask

  task automatic run_retire(input int n, input int budget, input string nm);
    int tgt, k;
    tgt = retired + n;
    k = 0;
    while (retired < tgt && k < budget) begin
      step(0, 32'h0);
      k++;
    end
    chk(nm, (retired >= tgt), 1);
  endtask

  localparam logic [31:0] A_PC [8] = '{32'd0, 32'd2, 32'd4, 32'd8, 32'd10, 32'd12, 32'd14, 32'd18};
  localparam logic [31:0] A_IN [8] = '{32'h4581, 32'h4501, 32'h0001_0013, 32'h4601,
                                       32'h4605, 32'h4609, 32'h0010_0513, 32'h0000_0013};
  localparam bit A_RV [8] = '{1, 1, 0, 1, 1, 1, 0, 0};

  initial begin
    int k, r0;
    bit fl;
    cpurst_n = 1'b0; flush = 1'b0; flush_pc = '0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = '0; instr_ready = 1'b0;

    // Straight-line 32-bit code, 1-cycle SRAM: one instruction per cycle.
    for (int i = 0; i < 256; i++)
      image[i] = {16'(2*i+1), 16'h0013, 16'(2*i), 16'h0013};
    do_reset();
    run_retire(1, 50, "b_first_instr");
    expect_stream = 1;
    repeat (20) step(0, 32'h0);
    expect_stream = 0;
    chk("b_pc0", log_pc[0], 32'd0);  chk("b_in0", log_in[0], 32'h0000_0013);
    chk("b_pc1", log_pc[1], 32'd4);  chk("b_in1", log_in[1], 32'h0001_0013);
    chk("b_pc2", log_pc[2], 32'd8);  chk("b_in2", log_in[2], 32'h0002_0013);

    // Mixed 16/32-bit code with a 32-bit instruction split at pc 14.
    for (int i = 0; i < 256; i++) image[i] = {$urandom, $urandom};
    image[0] = 64'h0001_0013_4501_4581;
    image[1] = 64'h0513_4609_4605_4601;
    image[2] = 64'h0000_0000_0013_0010;
    slow_word = 2; watch14 = 1; wait14 = 0;
    do_reset();
    run_retire(8, 300, "a_retire");
    for (int i = 0; i < 8; i++) begin
      chk("a_pc", log_pc[i], A_PC[i]);
      chk("a_instr", log_in[i], A_IN[i]);
      chk("a_rv16", log_rv[i], A_RV[i]);
    end
    chk("a_split_waits", (wait14 >= 5), 1);
    slow_word = -1; watch14 = 0;

    // Redirect with two reads in flight: both must be discarded.
    lat_lo = 3; lat_hi = 4; ir_mode = 1;
    step(1, 32'h40);
    k = 0;
    while (sq_adr.size() < 2 && k < 100) begin step(0, 32'h0); k++; end
    chk("two_outstanding", sq_adr.size(), 2);
    step(1, 32'h106);
    log_pc.delete(); log_in.delete(); log_rv.delete();
    ir_mode = 0;
    run_retire(1, 100, "flush_first");
    chk("flush_first_pc", log_pc[0], 32'h106);
    run_retire(10, 200, "flush_more");

    // Decode stall: fetch must stop when the queue is full, nothing lost.
    lat_lo = 1; lat_hi = 2; ir_mode = 1;
    repeat (20) step(0, 32'h0);
    chk("stall_req_blocked", last_req_valid, 0);
    ir_mode = 0;
    run_retire(20, 200, "stall_resume");

    // Random traffic, latencies and redirects (including back-to-back).
    lat_lo = 1; lat_hi = 4; rr_rand = 1; ir_mode = 2; r0 = retired;
    for (int c = 0; c < 3000; c++) begin
      fl = prev_fl ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 59) == 0);
      step(fl, $urandom & 32'h0000_07FE);
    end
    chk("random_progress", (retired - r0 > 200), 1);

    // Reset in the middle of a burst restarts at BOOT_ADDR.
    rr_rand = 0; ir_mode = 0;
    repeat (10) step(0, 32'h0);
    do_reset();
    run_retire(1, 50, "post_reset");
    chk("post_reset_pc", log_pc[0], BOOT);
    run_retire(10, 100, "post_reset_more");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
